// File: rtl/amba3_apb_regbank.sv
// APB3 completer backed by a bank of NUM_REGS word registers with optional
// read-only slots, programmable wait states and error responses.
module amba3_apb_regbank #(
  parameter int                      ADDR_SIZE   = 32,
  parameter int                      DATA_SIZE   = 32,
  parameter int                      NUM_REGS    = 16,
  parameter logic [ADDR_SIZE-1:0]    BASE_ADDR   = '0,
  parameter int                      WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]     RO_MASK     = '0
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [ADDR_SIZE-1:0]          paddr,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [DATA_SIZE-1:0]          pwdata,
  output logic                          pready,
  output logic [DATA_SIZE-1:0]          prdata,
  output logic                          pslverr,
  output logic [NUM_REGS*DATA_SIZE-1:0] reg_q,
  input  logic [NUM_REGS*DATA_SIZE-1:0] hw_rdata,
  output logic [NUM_REGS-1:0]           wr_pulse
);
  localparam int LSB   = $clog2(DATA_SIZE / 8);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((1 << LSB) - 1);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t               r_state, w_state_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic                 r_write, w_write_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic                 r_err, w_err_next;
  logic                 r_pready, w_pready_next;
  logic [DATA_SIZE-1:0] r_prdata, w_prdata_next;
  logic                 r_pslverr, w_pslverr_next;
  logic                 w_commit;
  logic [NUM_REGS-1:0]  r_wr_pulse;
  logic [DATA_SIZE-1:0] r_regs   [NUM_REGS];
  logic [DATA_SIZE-1:0] w_rd_vals[NUM_REGS];

  logic [ADDR_SIZE-1:0] w_off, w_word;
  logic [IDX_W-1:0]     w_dec_idx, w_sel_idx;
  logic                 w_dec_err, w_sel_err, w_sel_write;
  logic [DATA_SIZE-1:0] w_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign reg_q[gi*DATA_SIZE +: DATA_SIZE] = r_regs[gi];
      assign w_rd_vals[gi] = RO_MASK[gi] ? hw_rdata[gi*DATA_SIZE +: DATA_SIZE] : r_regs[gi];
    end
  endgenerate

  always_comb begin
    w_off     = paddr - BASE_ADDR;
    w_word    = w_off >> LSB;
    w_dec_idx = w_word[IDX_W-1:0];
    w_dec_err = (paddr < BASE_ADDR) || ((w_off & ALIGN_MASK) != '0) ||
                (w_word >= ADDR_SIZE'(NUM_REGS));
    if (!w_dec_err && pwrite && RO_MASK[w_dec_idx]) begin
      w_dec_err = 1'b1;
    end
  end

  // With zero wait states the response is loaded on the setup edge, so the
  // live decode is used there; otherwise the latched decode is used.
  always_comb begin
    w_sel_idx   = (r_state == S_IDLE) ? w_dec_idx : r_idx;
    w_sel_err   = (r_state == S_IDLE) ? w_dec_err : r_err;
    w_sel_write = (r_state == S_IDLE) ? pwrite    : r_write;
    w_rd_data   = (w_sel_err || w_sel_write) ? '0 : w_rd_vals[w_sel_idx];
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_write_next   = r_write;
    w_idx_next     = r_idx;
    w_err_next     = r_err;
    w_pready_next  = r_pready;
    w_prdata_next  = r_prdata;
    w_pslverr_next = r_pslverr;
    w_commit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_state_next = S_ACCESS;
          w_cnt_next   = WAIT_INIT;
          w_write_next = pwrite;
          w_idx_next   = w_dec_idx;
          w_err_next   = w_dec_err;
          if (WAIT_CYCLES == 0) begin
            w_pready_next  = 1'b1;
            w_prdata_next  = w_rd_data;
            w_pslverr_next = w_dec_err;
          end
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_next   = S_IDLE;
          w_cnt_next     = '0;
          w_pready_next  = 1'b0;
          w_prdata_next  = '0;
          w_pslverr_next = 1'b0;
        end else if (penable) begin
          if (r_pready) begin
            w_state_next   = S_IDLE;
            w_pready_next  = 1'b0;
            w_prdata_next  = '0;
            w_pslverr_next = 1'b0;
            w_commit       = r_write && !r_err;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              w_pready_next  = 1'b1;
              w_prdata_next  = w_rd_data;
              w_pslverr_next = r_err;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_write   <= w_write_next;
      r_idx     <= w_idx_next;
      r_err     <= w_err_next;
      r_pready  <= w_pready_next;
      r_prdata  <= w_prdata_next;
      r_pslverr <= w_pslverr_next;
    end
  end

  // pwdata is taken at the completing edge; APB keeps it stable for the transfer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit && (r_idx == IDX_W'(i));
        if (w_commit && (r_idx == IDX_W'(i))) begin
          r_regs[i] <= pwdata;
        end
      end
    end
  end

  assign pready   = r_pready;
  assign prdata   = r_prdata;
  assign pslverr  = r_pslverr;
  assign wr_pulse = r_wr_pulse;
endmodule

// File: tb/tb_amba3_apb_regbank.sv
// Bench for amba3_apb_regbank: two completers (0 and 3 wait states) driven by
// directed and random APB transfers, checked against an address-map model.
module tb_amba3_apb_regbank;
  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [15:0] RO    = 16'h0001;
  localparam logic [31:0] HW0   = 32'h1234_5678;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        psel0 = 1'b0, psel3 = 1'b0;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic [NREGS*32-1:0] reg_q0, reg_q3, hw_rdata;
  logic [NREGS-1:0]    wr_pulse0, wr_pulse3;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] mdl [2][NREGS];

  always #5 pclk = ~pclk;

  amba3_apb_regbank #(.ADDR_SIZE(32), .DATA_SIZE(32), .NUM_REGS(NREGS), .BASE_ADDR(BASE),
                      .WAIT_CYCLES(0), .RO_MASK(RO)) dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .reg_q(reg_q0), .hw_rdata(hw_rdata), .wr_pulse(wr_pulse0));

  amba3_apb_regbank #(.ADDR_SIZE(32), .DATA_SIZE(32), .NUM_REGS(NREGS), .BASE_ADDR(BASE),
                      .WAIT_CYCLES(3), .RO_MASK(RO)) dut3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready3), .prdata(prdata3),
    .pslverr(pslverr3), .reg_q(reg_q3), .hw_rdata(hw_rdata), .wr_pulse(wr_pulse3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input bit wr, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || (off % 4) != 0 || (off / 4) >= NREGS) return 1'b1;
    if (wr && RO[int'(off / 4)]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
    if (m_err(1'b0, a)) return 32'h0;
    if (RO[m_idx(a)]) return hw_rdata[m_idx(a)*32 +: 32];
    return mdl[d][m_idx(a)];
  endfunction

  task automatic check_bank(input int d, input string tag);
    for (int i = 0; i < NREGS; i++) begin
      check(tag, d ? reg_q3[i*32 +: 32] : reg_q0[i*32 +: 32], mdl[d][i]);
    end
  endtask

  task automatic set_psel(input int d, input logic v);
    if (d == 0) psel0 = v;
    else        psel3 = v;
  endtask

  // Called at #1 after a rising edge; the calling cycle is the setup phase.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int          waits;
    bit          ok;
    bit          e_err;
    logic [31:0] e_rd;
    logic [31:0] rd;
    logic        se;
    logic [15:0] e_pulse;
    e_err = m_err(wr, a);
    e_rd  = wr ? 32'h0 : m_read(d, a);
    set_psel(d, 1'b1);
    penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (d ? pready3 : pready0) begin ok = 1'b1; break; end
      check("prdata_in_wait", d ? prdata3 : prdata0, 32'h0);
      waits++;
      @(posedge pclk); #1;
    end
    check("pready_timeout", ok, 1'b1);
    rd = d ? prdata3 : prdata0;
    se = d ? pslverr3 : pslverr0;
    check("wait_states", waits, d ? 3 : 0);
    check("pslverr", se, e_err);
    check("prdata", rd, e_rd);
    @(posedge pclk); #1;
    set_psel(d, 1'b0); penable = 1'b0;
    e_pulse = '0;
    if (wr && !e_err) begin
      mdl[d][m_idx(a)] = wd;
      e_pulse[m_idx(a)] = 1'b1;
    end
    check("wr_pulse", d ? wr_pulse3 : wr_pulse0, e_pulse);
    check("pready_after", d ? pready3 : pready0, 1'b0);
    if (!m_err(1'b0, a)) check("reg_q", d ? reg_q3[m_idx(a)*32 +: 32] : reg_q0[m_idx(a)*32 +: 32], mdl[d][m_idx(a)]);
    $display("xfer dut%0d %s addr=%h wdata=%h rdata=%h slverr=%0d waits=%0d",
             d ? 3 : 0, wr ? "WR" : "RD", a, wd, rd, se, waits);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge pclk); #1; end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREGS; i++) mdl[d][i] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int          d;
    bit          wr;
    for (int i = 0; i < NREGS; i++) hw_rdata[i*32 +: 32] = $urandom;
    hw_rdata[31:0] = HW0;
    clear_model();

    // Reset state
    idle(3);
    check("rst_pready0", pready0, 1'b0);
    check("rst_prdata3", prdata3, 32'h0);
    check("rst_pslverr3", pslverr3, 1'b0);
    check("rst_wr_pulse0", wr_pulse0, 16'h0);
    preset = 1'b0;
    idle(1);
    check_bank(0, "rst_reg_q0");
    check_bank(1, "rst_reg_q3");

    // Zero wait states: write, pulse clears, read back
    apb_xfer(0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
    idle(1);
    check("wr_pulse_clear", wr_pulse0, 16'h0);
    apb_xfer(0, 1'b0, BASE + 32'h8, 32'h0);

    // Three wait states on register 5
    apb_xfer(1, 1'b1, BASE + 32'h14, 32'hCAFE_0005);
    apb_xfer(1, 1'b0, BASE + 32'h14, 32'h0);

    // Read-only register 0 sourced from hw_rdata
    apb_xfer(0, 1'b0, BASE, 32'h0);
    apb_xfer(0, 1'b1, BASE, 32'hFFFF_FFFF);
    apb_xfer(0, 1'b0, BASE, 32'h0);
    apb_xfer(1, 1'b1, BASE, 32'h1111_2222);

    // Error cases: beyond the bank, unaligned, below the base
    apb_xfer(0, 1'b0, BASE + NREGS * 4, 32'h0);
    apb_xfer(0, 1'b1, BASE + 32'h2, 32'h5555_AAAA);
    apb_xfer(1, 1'b1, BASE - 32'h4, 32'h7777_7777);
    check_bank(0, "err_bank0");

    // Abort a write during a wait state
    psel3 = 1'b1; penable = 1'b0; paddr = BASE + 32'hC; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5;
    idle(1);
    penable = 1'b1;
    idle(1);
    check("abort_pready", pready3, 1'b0);
    psel3 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("abort_wr_pulse", wr_pulse3, 16'h0);
    end
    check_bank(1, "abort_bank3");

    // Back-to-back write/read pairs
    apb_xfer(1, 1'b1, BASE + 32'hC, 32'h0BAD_F00D);
    apb_xfer(1, 1'b0, BASE + 32'hC, 32'h0);
    apb_xfer(0, 1'b1, BASE + 32'h3C, 32'h600D_CAFE);
    apb_xfer(0, 1'b0, BASE + 32'h3C, 32'h0);

    // Reset during a wait state
    psel3 = 1'b1; penable = 1'b0; paddr = BASE + 32'h10; pwrite = 1'b1; pwdata = 32'h1357_9BDF;
    idle(1);
    penable = 1'b1;
    idle(1);
    preset = 1'b1;
    #1;
    check("midrst_pready", pready3, 1'b0);
    check("midrst_prdata", prdata3, 32'h0);
    check("midrst_pslverr", pslverr3, 1'b0);
    clear_model();
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    idle(1);
    preset = 1'b0;
    idle(1);
    check("midrst_wr_pulse", wr_pulse3, 16'h0);
    check_bank(1, "midrst_bank3");
    check_bank(0, "midrst_bank0");
    apb_xfer(1, 1'b1, BASE + 32'h10, 32'h2468_ACE0);
    apb_xfer(1, 1'b0, BASE + 32'h10, 32'h0);

    // Random traffic against the model
    for (int t = 0; t < 50; t++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = BASE + NREGS * 4 + 4 * $urandom_range(0, 3);
        1:       a = BASE + 4 * $urandom_range(0, NREGS - 1) + $urandom_range(1, 3);
        2:       a = BASE - 4 * $urandom_range(1, 4);
        default: a = BASE + 4 * $urandom_range(0, NREGS - 1);
      endcase
      apb_xfer(d, wr, a, wd);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    check_bank(0, "final_bank0");
    check_bank(1, "final_bank3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
